// File: rtl/sti_rx.sv
// STI serial receiver: rebuilds the 16-bit parallel word from 8/16/24/32-bit
// serial frames. It also flags frame aborts, stray bits and non-zero pad bits.
module sti_rx #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [1:0]       cfg_length,
    input  logic             cfg_msb,
    input  logic             cfg_low,
    input  logic             cfg_fill,
    input  logic             si_data,
    input  logic             si_valid,
    output logic [15:0]      po_data,
    output logic             po_valid,
    output logic             pad_err,
    output logic             po_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECV, S_DONE} state_t;
    typedef enum logic [1:0] {LEN_8, LEN_16, LEN_24, LEN_32} len_t;

    state_t            state_q, state_d;
    len_t              len_q;
    logic              msb_q, low_q, fill_q;
    logic [4:0]        cnt_q;
    logic [31:0]       frame_q, frame_d;
    logic [15:0]       po_data_q;
    logic              pad_err_q, po_err_q, po_err_d;
    logic [CNT_W-1:0]  frame_cnt_q;

    logic              cfg_accept;
    logic              capture;
    logic [4:0]        wr_pos;
    logic [15:0]       payload;
    logic              pad;

    assign cfg_accept = (state_q == S_IDLE) && cfg_load;
    assign capture    = si_valid && ((state_q == S_ARMED) || (state_q == S_RECV));

    // cnt_q counts down from L-1, so for MSB-first it is the frame bit index
    // directly, and for LSB-first the index is (L-1) - cnt_q.
    assign wr_pos = msb_q ? cnt_q : ({len_q, 3'b111} - cnt_q);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every combinational output gets a default first; a path that leaves
    // a variable unassigned infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (cfg_load) state_d = S_ARMED;
            S_ARMED: if (si_valid) state_d = S_RECV;
            S_RECV: begin
                if (!si_valid)        state_d = S_IDLE;
                else if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: state-decoded outputs ----------------
    always_comb begin
        po_valid = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            S_ARMED, S_RECV: busy     = 1'b1;
            S_DONE:          po_valid = 1'b1;
            default: ;
        endcase
    end

    // Aborts and stray bits are reported in the cycle after they are seen.
    always_comb begin
        po_err_d = 1'b0;
        unique case (state_q)
            S_IDLE:  po_err_d = si_valid;
            S_RECV:  po_err_d = !si_valid;
            S_DONE:  po_err_d = si_valid;
            default: po_err_d = 1'b0;
        endcase
    end

    // ---------------- Frame assembly ----------------
    always_comb begin
        frame_d = frame_q;
        if (cfg_accept) begin
            frame_d = '0;
        end else if (capture) begin
            frame_d[wr_pos] = si_data;
        end
    end

    // Extraction works on frame_d so the final bit is included in the same
    // edge that enters DONE.
    always_comb begin
        payload = frame_d[15:0];
        pad     = 1'b0;
        unique case (len_q)
            LEN_8:  payload = low_q ? {frame_d[7:0], 8'h00} : {8'h00, frame_d[7:0]};
            LEN_16: payload = frame_d[15:0];
            LEN_24: begin
                payload = fill_q ? frame_d[23:8] : frame_d[15:0];
                pad     = fill_q ? |frame_d[7:0] : |frame_d[23:16];
            end
            LEN_32: begin
                payload = fill_q ? frame_d[31:16] : frame_d[15:0];
                pad     = fill_q ? |frame_d[15:0] : |frame_d[31:16];
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q       <= LEN_8;
            msb_q       <= 1'b0;
            low_q       <= 1'b0;
            fill_q      <= 1'b0;
            cnt_q       <= '0;
            frame_q     <= '0;
            po_data_q   <= '0;
            pad_err_q   <= 1'b0;
            po_err_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            frame_q  <= frame_d;
            po_err_q <= po_err_d;
            if (cfg_accept) begin
                len_q  <= len_t'(cfg_length);
                msb_q  <= cfg_msb;
                low_q  <= cfg_low;
                fill_q <= cfg_fill;
                cnt_q  <= {cfg_length, 3'b111};
            end else if (capture) begin
                cnt_q <= cnt_q - 5'd1;
            end
            if (state_d == S_DONE) begin
                po_data_q   <= payload;
                pad_err_q   <= pad;
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

    assign po_data   = po_data_q;
    assign pad_err   = pad_err_q;
    assign po_err    = po_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sti_rx.sv
// Directed bench for sti_rx: table of frame vectors plus hand-written
// sequences for aborts, stray bits, async reset and counter wrap.
module tb_sti_rx;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             cfg_load;
    logic [1:0]       cfg_length;
    logic             cfg_msb, cfg_low, cfg_fill;
    logic             si_data, si_valid;
    logic [15:0]      po_data;
    logic             po_valid, pad_err, po_err, busy;
    logic [CNT_W-1:0] frame_cnt;

    sti_rx #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .cfg_length (cfg_length),
        .cfg_msb    (cfg_msb),
        .cfg_low    (cfg_low),
        .cfg_fill   (cfg_fill),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .po_data    (po_data),
        .po_valid   (po_valid),
        .pad_err    (pad_err),
        .po_err     (po_err),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  len;
        logic        msb;
        logic        low;
        logic        fill;
        logic [31:0] frame;
        logic [15:0] exp_data;
        logic        exp_pad;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One-cycle cfg_load pulse; returns at the following falling edge.
    task automatic load_cfg(input logic [1:0] len, input logic msb, input logic low, input logic fill);
        cfg_length = len;
        cfg_msb    = msb;
        cfg_low    = low;
        cfg_fill   = fill;
        cfg_load   = 1'b1;
        @(negedge clk);
        cfg_load   = 1'b0;
    endtask

    // Serialises a frame the way the transmitter does; si_valid is left high.
    task automatic send_bits(input logic [1:0] len, input logic msb, input logic [31:0] frame);
        int n;
        n = 8 * (int'(len) + 1);
        for (int k = 0; k < n; k++) begin
            si_valid = 1'b1;
            si_data  = msb ? frame[n-1-k] : frame[k];
            @(negedge clk);
        end
    endtask

    // Called at the falling edge right after the last bit was sampled.
    task automatic check_frame(input string name, input logic [15:0] exp_data, input logic exp_pad);
        exp_cnt = exp_cnt + 1'b1;
        check({name, ".po_valid"},  32'(po_valid),  32'd1);
        check({name, ".po_data"},   32'(po_data),   32'(exp_data));
        check({name, ".pad_err"},   32'(pad_err),   32'(exp_pad));
        check({name, ".frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
        si_valid = 1'b0;
        @(negedge clk);
        check({name, ".pulse_end"}, {30'd0, po_valid, po_err}, 32'd0);
        check({name, ".hold"},      32'(po_data),   32'(exp_data));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_A5C3, 16'hA5C3, 1'b0};
        vecs[1]  = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_003C, 16'h3C00, 1'b0};
        vecs[2]  = '{2'b00, 1'b0, 1'b0, 1'b0, 32'h0000_003C, 16'h003C, 1'b0};
        vecs[3]  = '{2'b10, 1'b1, 1'b0, 1'b1, 32'h0012_3400, 16'h1234, 1'b0};
        vecs[4]  = '{2'b10, 1'b1, 1'b0, 1'b1, 32'h0012_3401, 16'h1234, 1'b1};
        vecs[5]  = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h0000_BEEF, 16'hBEEF, 1'b0};
        vecs[6]  = '{2'b11, 1'b1, 1'b0, 1'b1, 32'hCAFE_0000, 16'hCAFE, 1'b0};
        vecs[7]  = '{2'b11, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 16'hCAFE, 1'b1};
        vecs[8]  = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h8001_1234, 16'h1234, 1'b1};
        vecs[9]  = '{2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_ABCD, 16'hABCD, 1'b0};
        vecs[10] = '{2'b10, 1'b0, 1'b0, 1'b0, 32'h0001_ABCD, 16'hABCD, 1'b1};
        vecs[11] = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_0081, 16'h0081, 1'b0};

        reset = 1'b0; cfg_load = 1'b0; cfg_length = 2'b00;
        cfg_msb = 1'b0; cfg_low = 1'b0; cfg_fill = 1'b0;
        si_data = 1'b0; si_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset.outputs", {po_data, 11'd0, po_valid, pad_err, po_err, busy, 1'b0}, 32'd0);
        check("reset.frame_cnt", 32'(frame_cnt), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            load_cfg(vecs[i].len, vecs[i].msb, vecs[i].low, vecs[i].fill);
            check($sformatf("vec%0d.busy", i), 32'(busy), 32'd1);
            send_bits(vecs[i].len, vecs[i].msb, vecs[i].frame);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_pad);
        end

        // Abort: si_valid drops after 5 of 8 bits.
        load_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            si_valid = 1'b1;
            si_data  = k[0];
            @(negedge clk);
        end
        si_valid = 1'b0;
        @(negedge clk);
        check("abort.po_err",    32'(po_err),    32'd1);
        check("abort.po_valid",  32'(po_valid),  32'd0);
        check("abort.busy",      32'(busy),      32'd0);
        check("abort.frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        @(negedge clk);
        check("abort.pulse_end", 32'(po_err), 32'd0);

        // Stray bit in IDLE without cfg_load.
        si_valid = 1'b1;
        @(negedge clk);
        si_valid = 1'b0;
        check("stray_idle.po_err", 32'(po_err), 32'd1);
        check("stray_idle.busy",   32'(busy),   32'd0);
        @(negedge clk);
        check("stray_idle.pulse_end", 32'(po_err), 32'd0);

        // Stray bit together with cfg_load: error flagged, config still taken.
        si_valid = 1'b1;
        si_data  = 1'b1;
        load_cfg(2'b01, 1'b1, 1'b0, 1'b0);
        check("stray_cfg.po_err", 32'(po_err), 32'd1);
        check("stray_cfg.busy",   32'(busy),   32'd1);
        send_bits(2'b01, 1'b1, 32'h0000_5A5A);
        check_frame("stray_cfg", 16'h5A5A, 1'b0);

        // cfg_load while ARMED must not change the frame length.
        load_cfg(2'b00, 1'b0, 1'b1, 1'b0);
        load_cfg(2'b11, 1'b1, 1'b0, 1'b1);
        send_bits(2'b00, 1'b0, 32'h0000_00A7);
        check_frame("armed_cfg", 16'hA700, 1'b0);

        // Stray bit during DONE.
        load_cfg(2'b01, 1'b0, 1'b0, 1'b0);
        send_bits(2'b01, 1'b0, 32'h0000_1357);
        exp_cnt = exp_cnt + 1'b1;
        check("stray_done.po_valid", 32'(po_valid), 32'd1);
        check("stray_done.po_data",  32'(po_data),  32'h1357);
        @(negedge clk);
        si_valid = 1'b0;
        check("stray_done.po_err",   32'(po_err),   32'd1);
        check("stray_done.po_valid2", 32'(po_valid), 32'd0);
        @(negedge clk);
        check("stray_done.pulse_end", 32'(po_err), 32'd0);

        // Asynchronous reset in the middle of a 16-bit frame (after bit 10).
        load_cfg(2'b01, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            si_valid = 1'b1;
            si_data  = 1'b1;
            @(negedge clk);
        end
        check("mid_reset.busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset.outputs", {po_data, 11'd0, po_valid, pad_err, po_err, busy, 1'b0}, 32'd0);
        check("mid_reset.frame_cnt", 32'(frame_cnt), 32'd0);
        si_valid = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        load_cfg(2'b01, 1'b1, 1'b0, 1'b0);
        send_bits(2'b01, 1'b1, 32'h0000_0F0F);
        check_frame("post_reset", 16'h0F0F, 1'b0);

        // 255 more frames take frame_cnt from 1 around to 0.
        for (int i = 0; i < 255; i++) begin
            load_cfg(2'b00, 1'b1, 1'b0, 1'b0);
            send_bits(2'b00, 1'b1, 32'(i));
            check_frame($sformatf("wrap%0d", i), 16'(i & 8'hFF), 1'b0);
        end
        check("wrap.frame_cnt_zero", 32'(frame_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
